byte_striper_2l: RTL and testbench

- Sequences a single 8-bit byte stream onto the two-lane 8-bit register datapath by byte striping.
  - Even bytes go to lane 0, odd bytes to lane 1.
  - A lane pair is presented only when both slots are filled, or when a lone lane-0 byte is flushed with a pad byte.
- Sits between the byte source and the 2-in/2-out lane register stage; drives that stage's in0/in1 and owns the pair-level valid/ready handshake.

---
 rtl/byte_striper_2l.sv | 108 ++++++++++
 tb/tb_byte_striper_2l.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/byte_striper_2l.sv
// Stripes a byte stream onto two lanes (even->lane0, odd->lane1); pair valid one cycle after its odd byte.
// Stalls input while a pair is held; STRIPE_FLUSH_EN adds a PAD_BYTE flush of a lone lane-0 byte after FLUSH_WAIT idle cycles.
module byte_striper_2l #(
  parameter logic [7:0] PAD_BYTE   = 8'hF7,
  parameter int         FLUSH_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] lane0_out,
  output logic [7:0] lane1_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       lane1_pad
);

  typedef enum logic {EMPTY = 1'b0, HALF = 1'b1} state_t;

  state_t     state_q;
  logic [7:0] hold_q;
  logic [7:0] lane0_q;
  logic [7:0] lane1_q;
  logic       out_valid_q;

  logic       in_xfer;
  logic       out_xfer;
  logic       flush;
  logic       load_d;
  logic [7:0] lane1_d;

  assign in_ready  = !out_valid_q | out_ready;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid_q & out_ready;
  assign lane0_out = lane0_q;
  assign lane1_out = lane1_q;
  assign out_valid = out_valid_q;

`ifdef STRIPE_FLUSH_EN
  localparam logic [3:0] FW = 4'(FLUSH_WAIT);

  logic [3:0] idle_q;
  logic       lane1_pad_q;

  // A waiting data byte always beats the pad, hence the !in_valid term.
  assign flush     = (state_q == HALF) & (idle_q == FW) & !in_valid & in_ready;
  assign lane1_pad = lane1_pad_q;
`else
  logic unused_cfg;

  assign unused_cfg = ^FLUSH_WAIT;
  assign flush      = 1'b0;
  assign lane1_pad  = 1'b0;
`endif

  always_comb begin
    load_d  = (state_q == HALF) & (in_xfer | flush);
    lane1_d = flush ? PAD_BYTE : in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      hold_q      <= 8'h00;
      lane0_q     <= 8'h00;
      lane1_q     <= 8'h00;
      out_valid_q <= 1'b0;
`ifdef STRIPE_FLUSH_EN
      idle_q      <= 4'd0;
      lane1_pad_q <= 1'b0;
`endif
    end else begin
      // A new pair may overwrite the one leaving this cycle, so valid stays high.
      if (load_d) begin
        lane0_q     <= hold_q;
        lane1_q     <= lane1_d;
        out_valid_q <= 1'b1;
      end else if (out_xfer) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            hold_q  <= in_data;
            state_q <= HALF;
          end
        end
        HALF: begin
          if (load_d) state_q <= EMPTY;
        end
        default: state_q <= EMPTY;
      endcase

`ifdef STRIPE_FLUSH_EN
      if (load_d) lane1_pad_q <= flush;
      // Counting continues through a stall; the flush itself waits for in_ready.
      if (state_q == EMPTY) begin
        if (in_xfer) idle_q <= 4'd0;
      end else if (!in_xfer && idle_q != FW) begin
        idle_q <= idle_q + 4'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_byte_striper_2l.sv
// Randomised and directed stimulus for byte_striper_2l, checked every cycle against a byte-queue model.
module tb_byte_striper_2l;

  localparam int         FW  = 2;
  localparam logic [7:0] PAD = 8'hF7;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] lane0_out;
  logic [7:0] lane1_out;
  logic       out_valid;
  logic       out_ready;
  logic       lane1_pad;

  int errs   = 0;
  int checks = 0;

  byte_striper_2l #(.PAD_BYTE(PAD), .FLUSH_WAIT(FW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lane0_out (lane0_out),
    .lane1_out (lane1_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lane1_pad (lane1_pad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: bytes waiting for a partner, plus the pair most recently presented.
  logic [7:0] wait_q[$];
  int         wait_cycles;
  logic [7:0] m_l0, m_l1;
  logic       m_pad, m_vld;
  bit         chk_en = 1'b0;

  initial begin
    m_l0 = 0; m_l1 = 0; m_pad = 0; m_vld = 0; wait_cycles = 0;
  end

  always @(posedge clk) begin
    bit rdy, took, new_pair;
    if (reset) begin
      wait_q.delete();
      wait_cycles = 0;
      m_l0 = 0; m_l1 = 0; m_pad = 0; m_vld = 0;
    end else begin
      rdy      = !m_vld || out_ready;
      took     = in_valid && rdy;
      new_pair = 1'b0;
      if (took) begin
        if (wait_q.size() == 0) begin
          wait_q.push_back(in_data);
          wait_cycles = 0;
        end else begin
          m_l0 = wait_q.pop_front();
          m_l1 = in_data;
          m_pad = 1'b0;
          new_pair = 1'b1;
        end
      end else if (wait_q.size() == 1) begin
`ifdef STRIPE_FLUSH_EN
        if (wait_cycles >= FW && rdy) begin
          m_l0 = wait_q.pop_front();
          m_l1 = PAD;
          m_pad = 1'b1;
          new_pair = 1'b1;
        end else
`endif
        wait_cycles++;
      end
      if (new_pair) m_vld = 1'b1;
      else if (m_vld && out_ready) m_vld = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_val("in_ready",  {7'd0, in_ready},  {7'd0, (!m_vld || out_ready)});
      check_val("out_valid", {7'd0, out_valid}, {7'd0, m_vld});
      check_val("lane0",     lane0_out, m_l0);
      check_val("lane1",     lane1_out, m_l1);
      check_val("lane1_pad", {7'd0, lane1_pad}, {7'd0, m_pad});
    end
  end

  task automatic step(input logic v, input logic [7:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Holds a byte on the input until it is accepted, with a bounded wait.
  task automatic send(input logic [7:0] d, input logic r);
    bit acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) begin
      in_valid  = 1'b1;
      in_data   = d;
      out_ready = r;
      #3;
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check_val("send_timeout", 8'd0, 8'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;

    for (int i = 1; i <= 6; i++) step(1'b1, 8'(i), 1'b1);
    idle(4);

    step(1'b1, 8'h5A, 1'b1);
    idle(6);
`ifndef STRIPE_FLUSH_EN
    step(1'b1, 8'h5B, 1'b1);
    idle(2);
`endif

    step(1'b1, 8'h11, 1'b1);
    idle(2);
    step(1'b1, 8'h22, 1'b1);
    idle(6);

    send(8'h10, 1'b1);
    send(8'h11, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h12, 1'b0);
    send(8'h12, 1'b1);
    send(8'h13, 1'b1);
    idle(3);

    send(8'h77, 1'b1);
    reset = 1'b1;
    step(1'b0, 8'h00, 1'b1);
    reset = 1'b0;
    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    idle(3);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 299) == 0) reset = 1'b1;
      if ($urandom_range(0, 40) == 0) begin
        idle($urandom_range(1, 6));
      end else begin
        step($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 9) < 7);
      end
      reset = 1'b0;
    end
    idle(8);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
